// File: rtl/cmd_bus_arbiter_if.sv
// Downstream command bus shared by the arbiter and a sys_cmd register slave.
// The master issues a one-cycle sel; the slave answers with a one-cycle ack plus rdata.
interface intf_cmd #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32
);
    logic                 sel;
    logic                 rd_wr_n;
    logic [ADDR_BITS-1:0] byte_addr;
    logic [DATA_BITS-1:0] wdata;
    logic [DATA_BITS-1:0] rdata;
    logic                 ack;

    modport master (
        output sel, rd_wr_n, byte_addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  sel, rd_wr_n, byte_addr, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/cmd_bus_arbiter.sv
// Round-robin arbiter serialising NUM_REQ command sources onto one intf_cmd master port.
// A down-counting watchdog completes hung transactions with an error flag and a fill word.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no transaction; pick round-robin winner and latch its fields
// ST_ISSUE | cmd.sel high for this single cycle; watchdog loaded
// ST_WAIT  | waiting for cmd.ack or watchdog terminal count
// ST_RESP  | o_req_ack pulse to the winner; rr pointer advances
module cmd_bus_arbiter #(
    parameter int                       NUM_REQ       = 4,
    parameter int                       CMD_ADDR_BITS = 32,
    parameter int                       CMD_DATA_BITS = 32,
    parameter int                       TIMEOUT       = 64,
    parameter logic [CMD_DATA_BITS-1:0] ERR_DATA      = 32'hDEADBEEF
) (
    input  logic                             i_sysclk,
    input  logic                             i_arst_n,
    input  logic [NUM_REQ-1:0]               i_req_sel,
    input  logic [NUM_REQ-1:0]               i_req_rd_wr_n,
    input  logic [NUM_REQ*CMD_ADDR_BITS-1:0] i_req_byte_addr,
    input  logic [NUM_REQ*CMD_DATA_BITS-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]               o_req_ack,
    output logic [CMD_DATA_BITS-1:0]         o_req_rdata,
    output logic                             o_req_err,
    output logic                             o_busy,
    output logic [15:0]                      o_timeout_cnt,
    intf_cmd.master                          cmd
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic                     sel_q, sel_d;
    logic                     rd_wr_n_q, rd_wr_n_d;
    logic [CMD_ADDR_BITS-1:0] addr_q, addr_d;
    logic [CMD_DATA_BITS-1:0] wdata_q, wdata_d;
    logic [PTR_W-1:0]         grant_q, grant_d;
    logic [PTR_W-1:0]         rr_q, rr_d;
    logic [WD_W-1:0]          wd_q, wd_d;
    logic [NUM_REQ-1:0]       ack_q, ack_d;
    logic [CMD_DATA_BITS-1:0] rdata_q, rdata_d;
    logic                     err_q, err_d;
    logic                     busy_q, busy_d;
    logic [15:0]              tcnt_q, tcnt_d;

    logic [CMD_ADDR_BITS-1:0] req_addr  [NUM_REQ];
    logic [CMD_DATA_BITS-1:0] req_wdata [NUM_REQ];
    logic                     found;
    logic [PTR_W-1:0]         win;
    logic [PTR_W-1:0]         cand;
    logic                     wd_tc;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_addr[k]  = i_req_byte_addr[k*CMD_ADDR_BITS +: CMD_ADDR_BITS];
        assign req_wdata[k] = i_req_wdata[k*CMD_DATA_BITS +: CMD_DATA_BITS];
    end

    // First requester at or after the rr pointer, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(rr_q) + i) % NUM_REQ);
            if (!found && i_req_sel[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign wd_tc = (wd_q == '0);

    always_ff @(posedge i_sysclk or negedge i_arst_n) begin
        if (!i_arst_n) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (found) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (cmd.ack || wd_tc) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_d     = 1'b0;
        rd_wr_n_d = rd_wr_n_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        wd_d      = wd_q;
        ack_d     = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        tcnt_d    = tcnt_q;
        busy_d    = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d   = win;
                    rd_wr_n_d = i_req_rd_wr_n[win];
                    addr_d    = req_addr[win];
                    wdata_d   = req_wdata[win];
                    sel_d     = 1'b1;
                end
            end
            ST_ISSUE: wd_d = WD_W'(TIMEOUT - 1);
            ST_WAIT: begin
                // Ack has priority over a watchdog expiry in the same cycle.
                if (cmd.ack) begin
                    rdata_d        = cmd.rdata;
                    err_d          = 1'b0;
                    ack_d[grant_q] = 1'b1;
                end else if (wd_tc) begin
                    rdata_d        = ERR_DATA;
                    err_d          = 1'b1;
                    ack_d[grant_q] = 1'b1;
                    if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
                end else begin
                    wd_d = wd_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (grant_q == PTR_W'(NUM_REQ - 1)) rr_d = '0;
                else                                rr_d = grant_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_sysclk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            sel_q     <= 1'b0;
            rd_wr_n_q <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            grant_q   <= '0;
            rr_q      <= '0;
            wd_q      <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            sel_q     <= sel_d;
            rd_wr_n_q <= rd_wr_n_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            wd_q      <= wd_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign cmd.sel       = sel_q;
    assign cmd.rd_wr_n   = rd_wr_n_q;
    assign cmd.byte_addr = addr_q;
    assign cmd.wdata     = wdata_q;
    assign o_req_ack     = ack_q;
    assign o_req_rdata   = rdata_q;
    assign o_req_err     = err_q;
    assign o_busy        = busy_q;
    assign o_timeout_cnt = tcnt_q;
endmodule

// File: tb/tb_cmd_bus_arbiter.sv
// Directed bench for cmd_bus_arbiter: a small sys_cmd slave model with programmable
// ack delay, requester drivers, and hand-computed expected values.
module tb_cmd_bus_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_sel   = '0;
    logic [NR-1:0]   req_rd    = '1;
    logic [NR*AW-1:0] req_addr  = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR-1:0]   req_ack;
    logic [DW-1:0]   req_rdata;
    logic            req_err;
    logic            busy;
    logic [15:0]     tcnt;

    intf_cmd #(.ADDR_BITS(AW), .DATA_BITS(DW)) cmd_if ();

    cmd_bus_arbiter #(
        .NUM_REQ(NR), .CMD_ADDR_BITS(AW), .CMD_DATA_BITS(DW),
        .TIMEOUT(64), .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .i_sysclk        (clk),
        .i_arst_n        (rst_n),
        .i_req_sel       (req_sel),
        .i_req_rd_wr_n   (req_rd),
        .i_req_byte_addr (req_addr),
        .i_req_wdata     (req_wdata),
        .o_req_ack       (req_ack),
        .o_req_rdata     (req_rdata),
        .o_req_err       (req_err),
        .o_busy          (busy),
        .o_timeout_cnt   (tcnt),
        .cmd             (cmd_if)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc_now = 0;
    int sel_pulses = 0;

    always @(negedge clk) begin
        cyc_now++;
        if (cmd_if.sel) sel_pulses++;
    end

    // Slave model: unwritten words read back a fixed address-derived pattern.
    int          ack_delay = 1;
    int          pend_cnt  = 0;
    logic [31:0] pend_data = '0;
    logic [31:0] mem [16];
    bit          written [16];
    int          s_ix;
    int          inj_tok  = 0;
    int          inj_done = 0;

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return 32'h00A55A01 ^ {4{a[7:0]}};
    endfunction

    always @(posedge clk) begin
        #1;
        cmd_if.ack   = 1'b0;
        cmd_if.rdata = '0;
        if (!rst_n) pend_cnt = 0;
        if (inj_tok != inj_done) begin
            cmd_if.ack   = 1'b1;
            cmd_if.rdata = 32'h5555AAAA;
            inj_done     = inj_tok;
        end
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                cmd_if.ack   = 1'b1;
                cmd_if.rdata = pend_data;
            end
        end
        if (cmd_if.sel && ack_delay > 0) begin
            pend_cnt = ack_delay;
            s_ix     = int'(cmd_if.byte_addr[5:2]);
            if (!cmd_if.rd_wr_n) begin
                mem[s_ix]     = cmd_if.wdata;
                written[s_ix] = 1'b1;
                pend_data     = '0;
            end else begin
                pend_data = written[s_ix] ? mem[s_ix] : pattern(cmd_if.byte_addr);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic at_sample();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic rd, input logic [31:0] addr, input logic [31:0] wd);
        req_rd[k]              = rd;
        req_addr[k*AW +: AW]   = addr;
        req_wdata[k*DW +: DW]  = wd;
        req_sel[k]             = 1'b1;
    endtask

    task automatic drop(input int k);
        @(posedge clk);
        #1;
        req_sel[k] = 1'b0;
    endtask

    task automatic wait_ack(input int budget, output logic [3:0] ack, output logic [31:0] rd,
                            output logic err, output int t_ack, output int t_sel);
        ack = '0; rd = '0; err = 1'b0; t_ack = -1; t_sel = -1;
        for (int n = 0; n < budget; n++) begin
            at_sample();
            if (cmd_if.sel && t_sel < 0) t_sel = cyc_now;
            if (|req_ack) begin
                ack = req_ack; rd = req_rdata; err = req_err; t_ack = cyc_now;
                break;
            end
        end
        check_eq("ack_within_budget", 32'(t_ack >= 0), 32'd1);
    endtask

    logic [31:0] fair_exp [4] = '{32'h10B54A11, 32'h14B14E15, 32'h18BD4219, 32'h1CB9461D};

    initial begin
        #200000;
        $display("FAIL global_timeout: observed time %0t expected finish earlier", $time);
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [3:0]  a;
        logic [31:0] rd;
        logic        er;
        int          ta, ts, base, p0, prev;
        logic [3:0]  any_ack;

        repeat (3) @(posedge clk);
        at_sample();
        check_eq("rst_sel",     32'(cmd_if.sel), 32'd0);
        check_eq("rst_rd_wr_n", 32'(cmd_if.rd_wr_n), 32'd1);
        check_eq("rst_addr",    cmd_if.byte_addr, 32'd0);
        check_eq("rst_wdata",   cmd_if.wdata, 32'd0);
        check_eq("rst_ack",     32'(req_ack), 32'd0);
        check_eq("rst_rdata",   req_rdata, 32'd0);
        check_eq("rst_err",     32'(req_err), 32'd0);
        check_eq("rst_busy",    32'(busy), 32'd0);
        check_eq("rst_tcnt",    32'(tcnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single read from requester 0.
        base = cyc_now + 1;
        set_req(0, 1'b1, 32'h0, 32'h0);
        wait_ack(10, a, rd, er, ta, ts);
        check_eq("rd0_sel_cycle", 32'(ts - base), 32'd1);
        check_eq("rd0_ack_cycle", 32'(ta - base), 32'd3);
        check_eq("rd0_ack",   32'(a), 32'h1);
        check_eq("rd0_rdata", rd, 32'h00A55A01);
        check_eq("rd0_err",   32'(er), 32'd0);
        drop(0);

        // Write then read on requester 2.
        p0 = sel_pulses;
        set_req(2, 1'b0, 32'h4, 32'h12345678);
        wait_ack(10, a, rd, er, ta, ts);
        check_eq("wr2_ack", 32'(a), 32'h4);
        check_eq("wr2_err", 32'(er), 32'd0);
        drop(2);
        check_eq("wr2_sel_pulses", 32'(sel_pulses - p0), 32'd1);
        p0 = sel_pulses;
        set_req(2, 1'b1, 32'h4, 32'h0);
        wait_ack(10, a, rd, er, ta, ts);
        check_eq("rd2_ack",   32'(a), 32'h4);
        check_eq("rd2_rdata", rd, 32'h12345678);
        drop(2);
        check_eq("rd2_sel_pulses", 32'(sel_pulses - p0), 32'd1);

        // Fairness from rr=0 with every requester held high.
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        for (int k = 0; k < NR; k++) set_req(k, 1'b1, 32'h10 + 32'(4*k), 32'h0);
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            wait_ack(12, a, rd, er, ta, ts);
            check_eq($sformatf("fair%0d_ack", i), 32'(a), 32'(1 << (i % 4)));
            check_eq($sformatf("fair%0d_rdata", i), rd, fair_exp[i % 4]);
            if (i > 0) check_eq($sformatf("fair%0d_spacing", i), 32'(ta - prev), 32'd4);
            prev = ta;
        end
        @(posedge clk); #1;
        req_sel = '0;
        @(posedge clk); #1;

        // Timeout: slave never answers.
        ack_delay = 0;
        set_req(1, 1'b1, 32'h40, 32'h0);
        wait_ack(100, a, rd, er, ta, ts);
        check_eq("to_ack",     32'(a), 32'h2);
        check_eq("to_rdata",   rd, 32'hDEADBEEF);
        check_eq("to_err",     32'(er), 32'd1);
        check_eq("to_tcnt",    32'(tcnt), 32'd1);
        check_eq("to_latency", 32'(ta - ts), 32'd65);
        drop(1);

        // Late ack while idle must be ignored.
        p0 = sel_pulses;
        inj_tok++;
        any_ack = '0;
        repeat (4) begin
            at_sample();
            any_ack |= req_ack;
        end
        check_eq("late_ack_none",  32'(any_ack), 32'd0);
        check_eq("late_ack_rdata", req_rdata, 32'hDEADBEEF);
        check_eq("late_ack_tcnt",  32'(tcnt), 32'd1);
        check_eq("late_ack_busy",  32'(busy), 32'd0);
        check_eq("late_ack_sel",   32'(sel_pulses - p0), 32'd0);
        @(posedge clk); #1;

        // Ack lands on the watchdog's final WAIT cycle.
        ack_delay = 64;
        set_req(3, 1'b1, 32'h8, 32'h0);
        wait_ack(100, a, rd, er, ta, ts);
        check_eq("tie_ack",     32'(a), 32'h8);
        check_eq("tie_rdata",   rd, 32'h08AD5209);
        check_eq("tie_err",     32'(er), 32'd0);
        check_eq("tie_tcnt",    32'(tcnt), 32'd1);
        check_eq("tie_latency", 32'(ta - ts), 32'd65);
        drop(3);

        // Asynchronous reset while waiting on a hung slave.
        ack_delay = 0;
        set_req(1, 1'b1, 32'hC, 32'h0);
        repeat (5) at_sample();
        check_eq("arst_busy_before", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy",  32'(busy), 32'd0);
        check_eq("arst_sel",   32'(cmd_if.sel), 32'd0);
        check_eq("arst_rd",    32'(cmd_if.rd_wr_n), 32'd1);
        check_eq("arst_addr",  cmd_if.byte_addr, 32'd0);
        check_eq("arst_tcnt",  32'(tcnt), 32'd0);
        check_eq("arst_rdata", req_rdata, 32'd0);
        check_eq("arst_ack",   32'(req_ack), 32'd0);
        req_sel[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ack_delay = 1;
        base = cyc_now + 1;
        set_req(1, 1'b1, 32'hC, 32'h0);
        wait_ack(10, a, rd, er, ta, ts);
        check_eq("retry_ack_cycle", 32'(ta - base), 32'd3);
        check_eq("retry_ack",   32'(a), 32'h2);
        check_eq("retry_rdata", rd, 32'h0CA9560D);
        check_eq("retry_err",   32'(er), 32'd0);
        drop(1);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
